// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if -- bus bundle for the two-port memory arbiter.
//
// Carries both requester ports (p0 = CPU, p1 = video/DMA), the single
// downstream request channel and the arbiter status outputs.
//
//   pN_valid / pN_addr / pN_wstrb / pN_wdata : request from port N
//   pN_ready / pN_rdata                      : one-cycle completion to port N
//   ds_valid / ds_we / ds_addr / ds_wstrb / ds_wdata : downstream request
//   ds_ready / ds_rdata                      : downstream completion
//   owner / busy                             : arbiter status
//
// Modports:
//   slave  - the arbiter's view (consumes requests, drives downstream)
//   master - the surrounding system's view (requesters plus downstream)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              p0_valid;
    logic [ADDR_W-1:0] p0_addr;
    logic [3:0]        p0_wstrb;
    logic [31:0]       p0_wdata;
    logic              p0_ready;
    logic [31:0]       p0_rdata;

    logic              p1_valid;
    logic [ADDR_W-1:0] p1_addr;
    logic [3:0]        p1_wstrb;
    logic [31:0]       p1_wdata;
    logic              p1_ready;
    logic [31:0]       p1_rdata;

    logic              ds_valid;
    logic              ds_we;
    logic [ADDR_W-1:0] ds_addr;
    logic [3:0]        ds_wstrb;
    logic [31:0]       ds_wdata;
    logic              ds_ready;
    logic [31:0]       ds_rdata;

    logic              owner;
    logic              busy;

    modport slave (
        input  p0_valid, p0_addr, p0_wstrb, p0_wdata,
        output p0_ready, p0_rdata,
        input  p1_valid, p1_addr, p1_wstrb, p1_wdata,
        output p1_ready, p1_rdata,
        output ds_valid, ds_we, ds_addr, ds_wstrb, ds_wdata,
        input  ds_ready, ds_rdata,
        output owner, busy
    );

    modport master (
        output p0_valid, p0_addr, p0_wstrb, p0_wdata,
        input  p0_ready, p0_rdata,
        output p1_valid, p1_addr, p1_wstrb, p1_wdata,
        input  p1_ready, p1_rdata,
        input  ds_valid, ds_we, ds_addr, ds_wstrb, ds_wdata,
        output ds_ready, ds_rdata,
        input  owner, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter -- two-port memory arbiter with a single outstanding
// downstream transaction.
//
// Ports:
//   clk    - sole clock, rising edge
//   reset  - synchronous, active-high
//   bus    - mem_arbiter_if.slave: both requester ports, downstream
//            channel, owner/busy status
//
// Parameters:
//   ADDR_W   - address width on all ports
//   MAX_HOLD - max back-to-back port-1 grants while port 0 waits (1..15),
//              only meaningful in priority mode
//
// Build option:
//   MEM_ARB_VIDEO_PRIO_EN defined   -> port 1 wins contention until it has
//                                      been granted MAX_HOLD times in a row
//                                      while port 0 waited
//   MEM_ARB_VIDEO_PRIO_EN undefined -> round-robin on contention
//
// Sequence per transaction: IDLE (arbitrate, latch winner) -> GRANT
// (ds_valid held until ds_ready) -> DONE (one-cycle pN_ready) -> IDLE.
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              rr_q, rr_d;        // last granted port
    logic [3:0]        hold_q, hold_d;
    logic [31:0]       rdata_q, rdata_d;

    // Registered copy of the granted request; pure data, no reset needed.
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       wdata_q;

    logic              grant_en;
    logic              winner;

    // Contention resolution; a lone requester always wins.
    always_comb begin
        winner = bus.p1_valid;
        if (bus.p0_valid && bus.p1_valid) begin
`ifdef MEM_ARB_VIDEO_PRIO_EN
            winner = (hold_q == HOLD_MAX) ? 1'b0 : 1'b1;
`else
            winner = ~rr_q;
`endif
        end
    end

`ifndef MEM_ARB_VIDEO_PRIO_EN
    // Round-robin build has no use for the hold limit.
    logic unused_hold_cfg;
    assign unused_hold_cfg = ^HOLD_MAX;
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        hold_d   = hold_q;
        rdata_d  = rdata_q;
        grant_en = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.p0_valid || bus.p1_valid) begin
                    grant_en = 1'b1;
                    owner_d  = winner;
                    rr_d     = winner;
                    state_d  = GRANT;
`ifdef MEM_ARB_VIDEO_PRIO_EN
                    // Counts only port-1 grants that made port 0 wait.
                    if (!winner || !bus.p0_valid)
                        hold_d = 4'd0;
                    else if (hold_q != 4'hF)
                        hold_d = hold_q + 4'd1;
`else
                    hold_d = 4'd0;
`endif
                end
            end
            GRANT: begin
                if (bus.ds_ready) begin
                    // Writes keep the previous read data on pN_rdata.
                    if (wstrb_q == 4'b0000)
                        rdata_d = bus.ds_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            hold_q  <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (grant_en) begin
            addr_q  <= winner ? bus.p1_addr  : bus.p0_addr;
            wstrb_q <= winner ? bus.p1_wstrb : bus.p0_wstrb;
            wdata_q <= winner ? bus.p1_wdata : bus.p0_wdata;
        end
    end

    assign bus.ds_valid = (state_q == GRANT);
    assign bus.ds_we    = (wstrb_q != 4'b0000);
    assign bus.ds_addr  = addr_q;
    assign bus.ds_wstrb = wstrb_q;
    assign bus.ds_wdata = wdata_q;

    assign bus.p0_ready = (state_q == DONE) && !owner_q;
    assign bus.p1_ready = (state_q == DONE) &&  owner_q;
    assign bus.p0_rdata = rdata_q;
    assign bus.p1_rdata = rdata_q;

    assign bus.owner    = owner_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter -- self-checking bench for mem_arbiter.
// Transaction-level reference: the bench decides the winner from the
// arbitration rules (last owner / hold count kept as plain integers) and
// checks the downstream request, wait behaviour, completion pulse and
// return to idle for every transaction.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    localparam int ADDR_W   = 32;
    localparam int MAX_HOLD = 4;
`ifdef MEM_ARB_VIDEO_PRIO_EN
    localparam bit PRIO = 1'b1;
    int exp_seq[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`else
    localparam bit PRIO = 1'b0;
    int exp_seq[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always_ff @(posedge clk) cyc <= cyc + 1;

    // reference model state
    int          last_m;
    int          hold_m;
    logic [31:0] last_rd;
    logic [ADDR_W-1:0] r_addr[2];
    logic [3:0]        r_wstrb[2];
    logic [31:0]       r_wdata[2];
    int          grant_cyc;
    int          owner_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        r_addr[p]  = a;
        r_wstrb[p] = s;
        r_wdata[p] = d;
        if (p == 0) begin
            bus.p0_valid = 1'b1; bus.p0_addr = a; bus.p0_wstrb = s; bus.p0_wdata = d;
        end else begin
            bus.p1_valid = 1'b1; bus.p1_addr = a; bus.p1_wstrb = s; bus.p1_wdata = d;
        end
    endtask

    task automatic drop(input int p);
        if (p == 0) bus.p0_valid = 1'b0;
        else        bus.p1_valid = 1'b0;
    endtask

    task automatic rand_req(input int p);
        logic [3:0] s;
        s = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        set_req(p, $urandom, s, $urandom);
    endtask

    function automatic int pick();
        if (bus.p0_valid && !bus.p1_valid) return 0;
        if (!bus.p0_valid && bus.p1_valid) return 1;
        if (PRIO) return (hold_m == MAX_HOLD) ? 0 : 1;
        return (last_m == 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        last_m  = 0;
        hold_m  = 0;
        last_rd = 32'd0;
    endtask

    // Runs one complete transaction starting from IDLE with requests set up.
    task automatic serve(input int d, input logic [31:0] rd, input bit drop_early);
        int w;
        w = pick();
        if (PRIO) begin
            if (w == 0 || !bus.p0_valid) hold_m = 0;
            else                         hold_m++;
        end
        last_m = w;

        tick();  // grant edge
        grant_cyc = cyc;
        owner_log.push_back(int'(bus.owner));
        chk("grant_ds_valid", bus.ds_valid, 1);
        chk("grant_owner",    bus.owner, w);
        chk("grant_busy",     bus.busy, 1);
        chk("grant_addr",     bus.ds_addr, r_addr[w]);
        chk("grant_we",       bus.ds_we, r_wstrb[w] != 4'h0);
        chk("grant_wstrb",    bus.ds_wstrb, r_wstrb[w]);
        chk("grant_wdata",    bus.ds_wdata, r_wdata[w]);
        chk("grant_ready",    {bus.p0_ready, bus.p1_ready}, 0);

        for (int i = 0; i < d; i++) begin
            if (drop_early && i == 0) drop(w);
            bus.ds_ready = 1'b0;
            bus.ds_rdata = $urandom;
            tick();
            chk("wait_ds_valid", bus.ds_valid, 1);
            chk("wait_addr",     bus.ds_addr, r_addr[w]);
            chk("wait_wstrb",    bus.ds_wstrb, r_wstrb[w]);
            chk("wait_wdata",    bus.ds_wdata, r_wdata[w]);
            chk("wait_ready",    {bus.p0_ready, bus.p1_ready}, 0);
        end

        bus.ds_ready = 1'b1;
        bus.ds_rdata = rd;
        tick();  // completion edge
        bus.ds_ready = 1'b0;
        chk("done_ds_valid", bus.ds_valid, 0);
        chk("done_busy",     bus.busy, 1);
        chk("done_owner",    bus.owner, w);
        chk("done_p0_ready", bus.p0_ready, w == 0);
        chk("done_p1_ready", bus.p1_ready, w == 1);
        if (r_wstrb[w] == 4'h0) begin
            last_rd = rd;
            chk("done_rdata", (w == 0) ? bus.p0_rdata : bus.p1_rdata, rd);
        end
        drop(w);

        tick();
        chk("idle_busy",     bus.busy, 0);
        chk("idle_ds_valid", bus.ds_valid, 0);
        chk("idle_ready",    {bus.p0_ready, bus.p1_ready}, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.p0_valid = 1'b0;
        bus.p1_valid = 1'b0;
        bus.ds_ready = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        reset = 1'b1;
        bus.p0_valid = 1'b0; bus.p0_addr = '0; bus.p0_wstrb = '0; bus.p0_wdata = '0;
        bus.p1_valid = 1'b0; bus.p1_addr = '0; bus.p1_wstrb = '0; bus.p1_wdata = '0;
        bus.ds_ready = 1'b0; bus.ds_rdata = '0;
        model_reset();
        repeat (3) tick();

        chk("rst_ds_valid", bus.ds_valid, 0);
        chk("rst_busy",     bus.busy, 0);
        chk("rst_owner",    bus.owner, 0);
        chk("rst_ready",    {bus.p0_ready, bus.p1_ready}, 0);
        chk("rst_rdata",    bus.p0_rdata, 0);
        reset = 1'b0;

        // stray ds_ready while idle must be ignored
        bus.ds_ready = 1'b1;
        tick();
        bus.ds_ready = 1'b0;
        chk("idle_dsr_busy",  bus.busy, 0);
        chk("idle_dsr_ready", {bus.p0_ready, bus.p1_ready}, 0);
        tick();
        chk("idle_dsr_ready2", {bus.p0_ready, bus.p1_ready}, 0);
        chk("idle_dsr_rdata",  bus.p0_rdata, 0);

        // single port-0 read, response two cycles after ds_valid
        set_req(0, 32'h40000010, 4'b0000, $urandom);
        serve(2, 32'hDEADBEEF, 1'b0);

        // port-0 partial write held for three cycles
        set_req(0, $urandom, 4'b0011, 32'h12345678);
        serve(3, $urandom, 1'b0);

        // port-1 drops valid after one GRANT cycle; access still completes
        set_req(1, $urandom, 4'b0000, $urandom);
        serve(3, $urandom, 1'b1);

        // continuous contention; a lone port-1 access sets the starting point
        do_reset();
        set_req(1, $urandom, 4'b0000, $urandom);
        serve(0, $urandom, 1'b0);
        owner_log.delete();
        rand_req(0);
        rand_req(1);
        prev = 0;
        for (int k = 0; k < 10; k++) begin
            serve(0, $urandom, 1'b0);
            if (k > 0) chk("grant_spacing", grant_cyc - prev, 3);
            prev = grant_cyc;
            rand_req(owner_log[k]);
        end
        for (int k = 0; k < 10; k++)
            chk("grant_order", owner_log[k], exp_seq[k]);

        // reset while GRANT with ds_ready pending abandons the transaction
        do_reset();
        set_req(0, $urandom, 4'b0000, $urandom);
        tick();
        chk("rstg_ds_valid", bus.ds_valid, 1);
        bus.ds_ready = 1'b1;
        reset = 1'b1;
        drop(0);
        tick();
        reset = 1'b0;
        bus.ds_ready = 1'b0;
        model_reset();
        chk("rstg_ds_valid_after", bus.ds_valid, 0);
        chk("rstg_busy",           bus.busy, 0);
        chk("rstg_ready",          {bus.p0_ready, bus.p1_ready}, 0);
        chk("rstg_rdata",          bus.p0_rdata, 0);
        tick();
        chk("rstg_ready2",         {bus.p0_ready, bus.p1_ready}, 0);
        set_req(1, $urandom, 4'b0000, $urandom);
        serve(1, $urandom, 1'b0);

        // randomized traffic on both ports
        for (int it = 0; it < 40; it++) begin
            if (!bus.p0_valid && ($urandom % 2 == 0)) rand_req(0);
            if (!bus.p1_valid && ($urandom % 2 == 0)) rand_req(1);
            if (!bus.p0_valid && !bus.p1_valid) rand_req(int'($urandom % 2));
            serve(int'($urandom % 4), $urandom, ($urandom % 4) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
